// File: rtl/pe_regfile_bus_pkg.sv
// ============================================================================
// Module   : pe_regfile_bus_pkg
// Purpose  : Shared types and constants for the PE register-file / bus stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pe_regfile_bus_pkg;

    localparam int                    REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] X0_ADDR    = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

endpackage

`default_nettype wire

// File: rtl/pe_regfile_bus_if.sv
// ============================================================================
// Module   : pe_regfile_bus_if
// Purpose  : PE-side handshake plus data-memory req/ack bus of the stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pe_regfile_bus_if #(
    parameter int XLEN = 32
);
    import pe_regfile_bus_pkg::*;

    logic                  read_en;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rd_write;
    logic [XLEN-1:0]       result_in;
    logic                  reg_select;
    logic                  mem_read;
    logic                  mem_write;
    logic [XLEN-1:0]       mem_address;
    logic [XLEN-1:0]       AmuxIn;
    logic [XLEN-1:0]       BmuxIn;
    logic                  data_Ready;
    logic                  mem_ack;
    logic                  mem_err;
    logic                  bus_req;
    logic                  bus_we;
    logic [XLEN-1:0]       bus_addr;
    logic [XLEN-1:0]       bus_wdata;
    logic [XLEN-1:0]       bus_rdata;
    logic                  bus_ack;

    // Master: the PE together with the memory; slave: the register/bus stage.
    modport master (
        output read_en, rs1, rs2, rd, rd_write, result_in, reg_select,
        output mem_read, mem_write, mem_address, bus_rdata, bus_ack,
        input  AmuxIn, BmuxIn, data_Ready, mem_ack, mem_err,
        input  bus_req, bus_we, bus_addr, bus_wdata
    );

    modport slave (
        input  read_en, rs1, rs2, rd, rd_write, result_in, reg_select,
        input  mem_read, mem_write, mem_address, bus_rdata, bus_ack,
        output AmuxIn, BmuxIn, data_Ready, mem_ack, mem_err,
        output bus_req, bus_we, bus_addr, bus_wdata
    );

endinterface

`default_nettype wire

// File: rtl/pe_regfile_bus_regfile.sv
// ============================================================================
// Module   : pe_regfile_bus_regfile
// Purpose  : NREGS x XLEN register array, 2 read / 1 write ports, x0 = 0.
//            Same-edge write forwarding when PE_RF_BYPASS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_regfile_bus_regfile
    import pe_regfile_bus_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] raddr_a_i,
    input  logic [REG_ADDR_W-1:0] raddr_b_i,
    output logic [XLEN-1:0]       rdata_a_o,
    output logic [XLEN-1:0]       rdata_b_o,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic [XLEN-1:0]       wdata_i
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != X0_ADDR)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = (raddr_a_i == X0_ADDR) ? '0 : regs_q[raddr_a_i];
        rdata_b_o = (raddr_b_i == X0_ADDR) ? '0 : regs_q[raddr_b_i];
`ifdef PE_RF_BYPASS_EN
        if (we_i && (waddr_i != X0_ADDR) && (waddr_i == raddr_a_i)) begin
            rdata_a_o = wdata_i;
        end
        if (we_i && (waddr_i != X0_ADDR) && (waddr_i == raddr_b_i)) begin
            rdata_b_o = wdata_i;
        end
`endif
    end

endmodule

`default_nettype wire

// File: rtl/pe_regfile_bus.sv
// ============================================================================
// Module   : pe_regfile_bus
// Purpose  : Register file, operand return and timed req/ack memory bus for
//            the processing element. Optional macro: PE_RF_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_regfile_bus
    import pe_regfile_bus_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    pe_regfile_bus_if.slave bus
);

    localparam int               CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             we_q, we_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [XLEN-1:0]  amux_q, amux_d;
    logic [XLEN-1:0]  bmux_q, bmux_d;
    logic             ready_q, ready_d;
    logic             pend_q, pend_d;

    logic [REG_ADDR_W-1:0] port_a_addr, port_b_addr;
    logic [XLEN-1:0]       port_a_data, port_b_data;
    logic [XLEN-1:0]       req_a, req_b;
    logic                  rd_req, req_valid;
    logic                  load_fin;
    logic [XLEN-1:0]       load_data;

    pe_regfile_bus_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .raddr_a_i (port_a_addr),
        .raddr_b_i (port_b_addr),
        .rdata_a_o (port_a_data),
        .rdata_b_o (port_b_data),
        .we_i      (bus.rd_write),
        .waddr_i   (bus.rd),
        .wdata_i   (bus.result_in)
    );

    // reg_select=1 turns the read strobe into "wait for load data only".
    assign rd_req    = bus.read_en && !bus.reg_select;
    assign req_valid = rd_req || pend_q;

`ifdef PE_RF_BYPASS_EN
    // Pending reads keep addresses and re-read at delivery, seeing later writes.
    logic [REG_ADDR_W-1:0] pend_rs1_q, pend_rs1_d;
    logic [REG_ADDR_W-1:0] pend_rs2_q, pend_rs2_d;

    assign port_a_addr = rd_req ? bus.rs1 : pend_rs1_q;
    assign port_b_addr = rd_req ? bus.rs2 : pend_rs2_q;
    assign req_a       = port_a_data;
    assign req_b       = port_b_data;
    assign pend_rs1_d  = rd_req ? bus.rs1 : pend_rs1_q;
    assign pend_rs2_d  = rd_req ? bus.rs2 : pend_rs2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_rs1_q <= '0;
            pend_rs2_q <= '0;
        end else begin
            pend_rs1_q <= pend_rs1_d;
            pend_rs2_q <= pend_rs2_d;
        end
    end
`else
    // Pending reads keep the data seen at the sampling edge.
    logic [XLEN-1:0] pend_a_q, pend_a_d;
    logic [XLEN-1:0] pend_b_q, pend_b_d;

    assign port_a_addr = bus.rs1;
    assign port_b_addr = bus.rs2;
    assign req_a       = rd_req ? port_a_data : pend_a_q;
    assign req_b       = rd_req ? port_b_data : pend_b_q;
    assign pend_a_d    = req_a;
    assign pend_b_d    = req_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_a_q <= '0;
            pend_b_q <= '0;
        end else begin
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        load_fin  = 1'b0;
        load_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.mem_write || bus.mem_read) begin
                    state_d = ST_REQ;
                    we_d    = bus.mem_write;
                    addr_d  = bus.mem_address;
                    wdata_d = bus.result_in;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_REQ, ST_WAIT: begin
                if (bus.bus_ack) begin
                    state_d   = ST_DONE;
                    load_fin  = !we_q;
                    load_data = bus.bus_rdata;
                end else if ((state_q == ST_WAIT) && (cnt_q == CNT_MAX)) begin
                    state_d  = ST_DONE;
                    err_d    = 1'b1;
                    load_fin = !we_q;
                end else begin
                    state_d = ST_WAIT;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A completing load owns AmuxIn; a coincident register read waits one cycle.
    always_comb begin
        amux_d  = amux_q;
        bmux_d  = bmux_q;
        ready_d = 1'b0;
        pend_d  = pend_q;
        if (load_fin) begin
            amux_d  = load_data;
            ready_d = 1'b1;
            pend_d  = req_valid;
        end else if (req_valid) begin
            amux_d  = req_a;
            bmux_d  = req_b;
            ready_d = 1'b1;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            amux_q  <= '0;
            bmux_q  <= '0;
            ready_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            amux_q  <= amux_d;
            bmux_q  <= bmux_d;
            ready_q <= ready_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.AmuxIn     = amux_q;
    assign bus.BmuxIn     = bmux_q;
    assign bus.data_Ready = ready_q;
    assign bus.mem_ack    = (state_q == ST_DONE);
    assign bus.mem_err    = (state_q == ST_DONE) && err_q;
    assign bus.bus_req    = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign bus.bus_we     = we_q;
    assign bus.bus_addr   = addr_q;
    assign bus.bus_wdata  = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_pe_regfile_bus.sv
// ============================================================================
// Module   : tb_pe_regfile_bus
// Purpose  : Directed self-checking bench for pe_regfile_bus (TIMEOUT = 8).
//            Expectations follow PE_RF_BYPASS_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_regfile_bus;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 8;

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
        bit          chk_b;
    } data_exp_t;

    typedef struct {
        string tag;
        logic  err;
    } mem_exp_t;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   nreq;

    data_exp_t dq[$];
    mem_exp_t  mq[$];
    data_exp_t de;
    mem_exp_t  me;

    pe_regfile_bus_if #(.XLEN(XLEN)) bif ();

    pe_regfile_bus #(
        .XLEN    (XLEN),
        .NREGS   (32),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic exp_data(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input bit chk_b);
        data_exp_t e;
        e.tag = tag; e.a = a; e.b = b; e.chk_b = chk_b;
        dq.push_back(e);
    endtask

    task automatic exp_mem(input string tag, input logic err);
        mem_exp_t e;
        e.tag = tag; e.err = err;
        mq.push_back(e);
    endtask

    // Called in the REQ cycle; answers on the ack_on-th bus_req cycle (0 = never).
    task automatic run_mem(input int ack_on, input logic [31:0] rdata, output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (bif.bus_req !== 1'b1) break;
            n++;
            if (n == ack_on) begin
                bif.bus_ack   = 1'b1;
                bif.bus_rdata = rdata;
            end
            tick();
            bif.bus_ack = 1'b0;
        end
    endtask

    // Scoreboard: every data_Ready / mem_ack pulse pops the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bif.data_Ready === 1'b1) begin
                if (dq.size() == 0) begin
                    check("unexpected_data_Ready", {31'b0, bif.data_Ready}, 32'd0);
                end else begin
                    de = dq.pop_front();
                    check({de.tag, "_AmuxIn"}, bif.AmuxIn, de.a);
                    if (de.chk_b) check({de.tag, "_BmuxIn"}, bif.BmuxIn, de.b);
                end
            end
            if (bif.mem_ack === 1'b1) begin
                if (mq.size() == 0) begin
                    check("unexpected_mem_ack", {31'b0, bif.mem_ack}, 32'd0);
                end else begin
                    me = mq.pop_front();
                    check({me.tag, "_mem_err"}, {31'b0, bif.mem_err}, {31'b0, me.err});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bif.read_en = 0; bif.rs1 = 0; bif.rs2 = 0; bif.rd = 0; bif.rd_write = 0;
        bif.result_in = 0; bif.reg_select = 0; bif.mem_read = 0; bif.mem_write = 0;
        bif.mem_address = 0; bif.bus_rdata = 0; bif.bus_ack = 0;
        tick(); tick();
        check("rst_AmuxIn", bif.AmuxIn, 32'h0);
        check("rst_BmuxIn", bif.BmuxIn, 32'h0);
        check("rst_ready", {31'b0, bif.data_Ready}, 32'd0);
        check("rst_bus_req", {31'b0, bif.bus_req}, 32'd0);
        check("rst_bus_addr", bif.bus_addr, 32'h0);
        check("rst_bus_wdata", bif.bus_wdata, 32'h0);
        reset = 1'b0;
        tick();

        // 1: write x5, read it back with x0 on port B
        bif.rd_write = 1; bif.rd = 5; bif.result_in = 32'hDEADBEEF;
        tick();
        bif.rd_write = 0;
        bif.read_en = 1; bif.rs1 = 5; bif.rs2 = 0;
        exp_data("t1_read_x5", 32'hDEADBEEF, 32'h0, 1);
        tick();
        bif.read_en = 0;
        tick();
        check("t1_ready_pulse", {31'b0, bif.data_Ready}, 32'd0);
        check("t1_hold", bif.AmuxIn, 32'hDEADBEEF);

        // 2: write to x0 is discarded
        bif.rd_write = 1; bif.rd = 0; bif.result_in = 32'h1234;
        tick();
        bif.rd_write = 0;
        bif.read_en = 1; bif.rs1 = 0; bif.rs2 = 5;
        exp_data("t2_read_x0", 32'h0, 32'hDEADBEEF, 1);
        tick();
        bif.read_en = 0;
        tick();

        // 3: same-edge write and read of x7
        bif.rd_write = 1; bif.rd = 7; bif.result_in = 32'hA5A5A5A5;
        bif.read_en = 1; bif.rs1 = 7; bif.rs2 = 7;
`ifdef PE_RF_BYPASS_EN
        exp_data("t3_same_edge", 32'hA5A5A5A5, 32'hA5A5A5A5, 1);
`else
        exp_data("t3_same_edge", 32'h0, 32'h0, 1);
`endif
        tick();
        bif.rd_write = 0; bif.read_en = 0;
        tick();
        bif.read_en = 1; bif.rs1 = 7; bif.rs2 = 0;
        exp_data("t3_after_write", 32'hA5A5A5A5, 32'h0, 1);
        tick();
        bif.read_en = 0;
        tick();

        // 4: load with ack on the 4th bus_req cycle
        bif.mem_read = 1; bif.mem_address = 32'h100;
        tick();
        bif.mem_read = 0;
        check("t4_bus_addr", bif.bus_addr, 32'h100);
        check("t4_bus_we", {31'b0, bif.bus_we}, 32'd0);
        exp_mem("t4_load", 1'b0);
        exp_data("t4_load", 32'hCAFEF00D, 32'h0, 0);
        run_mem(4, 32'hCAFEF00D, nreq);
        check("t4_req_cycles", nreq, 32'd4);
        check("t4_mem_ack", {31'b0, bif.mem_ack}, 32'd1);
        tick();
        check("t4_ack_pulse", {31'b0, bif.mem_ack}, 32'd0);

        // 5: read+write together (store wins), never acknowledged -> timeout
        bif.mem_read = 1; bif.mem_write = 1; bif.mem_address = 32'h200;
        bif.result_in = 32'h55;
        tick();
        bif.mem_read = 0; bif.mem_write = 0;
        check("t5_bus_we", {31'b0, bif.bus_we}, 32'd1);
        check("t5_bus_wdata", bif.bus_wdata, 32'h55);
        exp_mem("t5_timeout", 1'b1);
        run_mem(0, 32'h0, nreq);
        check("t5_req_cycles", nreq, TIMEOUT + 1);
        check("t5_mem_err", {31'b0, bif.mem_err}, 32'd1);
        tick();
        check("t5_err_pulse", {31'b0, bif.mem_err}, 32'd0);

        // 6: zero-wait load completing together with a register read of x3
        bif.rd_write = 1; bif.rd = 3; bif.result_in = 32'h11;
        tick();
        bif.rd_write = 0;
        bif.mem_read = 1; bif.mem_address = 32'h300;
        tick();
        bif.mem_read = 0;
        exp_mem("t6_load", 1'b0);
        exp_data("t6_load_first", 32'hBEEF0001, 32'h0, 0);
        exp_data("t6_pending_read", 32'h11, 32'hDEADBEEF, 1);
        bif.bus_ack = 1; bif.bus_rdata = 32'hBEEF0001;
        bif.read_en = 1; bif.rs1 = 3; bif.rs2 = 5;
        tick();
        bif.bus_ack = 0; bif.read_en = 0;
        check("t6_mem_ack", {31'b0, bif.mem_ack}, 32'd1);
        tick();
        tick();

        // reg_select masks the register read
        bif.read_en = 1; bif.reg_select = 1; bif.rs1 = 5;
        tick();
        bif.read_en = 0; bif.reg_select = 0;
        tick();
        check("sel_no_ready", {31'b0, bif.data_Ready}, 32'd0);
        check("sel_hold", bif.AmuxIn, 32'h11);

        // reset in WAIT: bus_req drops, no mem_ack, registers cleared
        bif.mem_read = 1; bif.mem_address = 32'h400;
        tick();
        bif.mem_read = 0;
        tick();
        check("rstw_in_wait", {31'b0, bif.bus_req}, 32'd1);
        reset = 1'b1;
        tick();
        check("rstw_bus_req", {31'b0, bif.bus_req}, 32'd0);
        reset = 1'b0;
        tick();
        check("rstw_no_ack", {31'b0, bif.mem_ack}, 32'd0);
        bif.read_en = 1; bif.rs1 = 5; bif.rs2 = 3;
        exp_data("rstw_regs_cleared", 32'h0, 32'h0, 1);
        tick();
        bif.read_en = 0;
        tick(); tick();

        check("left_data_exp", dq.size(), 32'd0);
        check("left_mem_exp", mq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
